// File: rtl/fta_asynch2sync_q_if.sv
// Bundle of upstream (pulse) and downstream (level) signals of the queued
// async-to-sync FTA bridge. The bridge sits on the "slave" modport and the
// surrounding environment on the "master" modport.
//
// Handshake semantics: upstream requests are single-cycle pulses on req_cyc_i
// with no ready; a request arriving while the queue is full and not popping
// is dropped and reported on ovf_o/ovf_tid_o. Downstream, req_cyc_o is a level
// held with stable req_*_o fields until the slave raises ack, rty or err
// (levels); the bridge answers upstream with one-cycle resp_*_o pulses and
// waits for the slave to release all response levels before the next issue.
interface fta_asynch2sync_q_if #(
  parameter int DW    = 128,
  parameter int AW    = 32,
  parameter int TW    = 13,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // upstream request side
  logic            req_cyc_i;
  logic            req_we_i;
  logic [AW-1:0]   req_adr_i;
  logic [DW-1:0]   req_dat_i;
  logic [DW/8-1:0] req_sel_i;
  logic [TW-1:0]   req_tid_i;
  logic            ovf_o;
  logic [TW-1:0]   ovf_tid_o;
  // upstream response side
  logic            resp_ack_o;
  logic            resp_rty_o;
  logic            resp_err_o;
  logic [DW-1:0]   resp_dat_o;
  logic [TW-1:0]   resp_tid_o;
  // downstream request side
  logic            req_cyc_o;
  logic            req_we_o;
  logic [AW-1:0]   req_adr_o;
  logic [DW-1:0]   req_dat_o;
  logic [DW/8-1:0] req_sel_o;
  logic [TW-1:0]   req_tid_o;
  // downstream response side
  logic            resp_ack_i;
  logic            resp_rty_i;
  logic            resp_err_i;
  logic [DW-1:0]   resp_dat_i;
  // status
  logic            busy_o;
  logic [CW-1:0]   count_o;

  modport slave (
    input  req_cyc_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, req_tid_i,
    input  resp_ack_i, resp_rty_i, resp_err_i, resp_dat_i,
    output ovf_o, ovf_tid_o,
    output resp_ack_o, resp_rty_o, resp_err_o, resp_dat_o, resp_tid_o,
    output req_cyc_o, req_we_o, req_adr_o, req_dat_o, req_sel_o, req_tid_o,
    output busy_o, count_o
  );

  modport master (
    output req_cyc_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, req_tid_i,
    output resp_ack_i, resp_rty_i, resp_err_i, resp_dat_i,
    input  ovf_o, ovf_tid_o,
    input  resp_ack_o, resp_rty_o, resp_err_o, resp_dat_o, resp_tid_o,
    input  req_cyc_o, req_we_o, req_adr_o, req_dat_o, req_sel_o, req_tid_o,
    input  busy_o, count_o
  );
endinterface

// File: rtl/fta_asynch2sync_q.sv
// Queued asynchronous-to-synchronous FTA bridge: pulse requests are queued in
// a DEPTH-entry FIFO, issued one at a time as a level cycle to the slave, and
// slave level responses are turned into single-cycle upstream pulses. Adds
// retry with backoff, response timeout, overflow reporting and tid tagging.
// BACKOFF must be >= 1.
module fta_asynch2sync_q #(
  parameter int DW        = 128,
  parameter int AW        = 32,
  parameter int TW        = 13,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 3,
  parameter int BACKOFF   = 4
) (
  input  logic               clk,
  input  logic               rst,
  fta_asynch2sync_q_if.slave bus,
  output logic [1:0]         dbg_state_o
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam int RW  = $clog2(MAX_RETRY + 2);
  localparam int BW  = $clog2(BACKOFF + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BACKOFF = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [DW/8-1:0] sel;
    logic [TW-1:0]   tid;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q;
  logic [TW-1:0]   ovf_tid_q;

  state_t          state_q, state_d;
  logic [TMW-1:0]  timer_q, timer_d, timer_inc;
  logic [RW-1:0]   retry_q, retry_d;
  logic [BW-1:0]   bo_q, bo_d;
  logic            req_cyc_q;
  logic            ack_q, ack_d, rty_q, rty_d, err_q, err_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [TW-1:0]   tid_q;

  logic            full, nonempty, push, pop, ovf, any_rsp;
  entry_t          head, wr_entry;

  assign full      = (count_q == CW'(DEPTH));
  assign nonempty  = (count_q != '0);
  assign push      = bus.req_cyc_i && (!full || pop);
  assign ovf       = bus.req_cyc_i && full && !pop;
  assign any_rsp   = bus.resp_ack_i | bus.resp_rty_i | bus.resp_err_i;
  assign head      = mem_q[rd_ptr_q];
  assign timer_inc = timer_q + TMW'(1);
  assign wr_entry  = '{we: bus.req_we_i, adr: bus.req_adr_i, dat: bus.req_dat_i,
                       sel: bus.req_sel_i, tid: bus.req_tid_i};

  // Queue storage; contents are only visible through the occupancy-gated head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Queue pointers, occupancy and overflow reporting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ovf_tid_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
      ovf_q     <= ovf;
      ovf_tid_q <= ovf ? bus.req_tid_i : '0;
    end
  end

  // Issue FSM: next state, counters and the upstream response to register.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    bo_d    = bo_q;
    pop     = 1'b0;
    ack_d   = 1'b0;
    rty_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (nonempty && !any_rsp) begin
          state_d = S_ISSUE;
          timer_d = '0;
        end
      end
      S_ISSUE: begin
        timer_d = timer_inc;
        if (bus.resp_err_i) begin
          err_d   = 1'b1;
          pop     = 1'b1;
          retry_d = '0;
          state_d = S_DRAIN;
        end else if (bus.resp_ack_i) begin
          ack_d   = 1'b1;
          dat_d   = bus.resp_dat_i;
          pop     = 1'b1;
          retry_d = '0;
          state_d = S_DRAIN;
        end else if (bus.resp_rty_i) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            rty_d   = 1'b1;
            pop     = 1'b1;
            retry_d = '0;
            state_d = S_DRAIN;
          end else begin
            retry_d = retry_q + RW'(1);
            bo_d    = '0;
            state_d = S_BACKOFF;
          end
        end else if (timer_inc == TMW'(TIMEOUT)) begin
          // Counting the current cycle, TIMEOUT silent cycles have elapsed.
          err_d   = 1'b1;
          pop     = 1'b1;
          retry_d = '0;
          state_d = S_DRAIN;
        end
      end
      S_BACKOFF: begin
        if (bo_q == BW'(BACKOFF - 1)) begin
          if (!any_rsp) begin
            state_d = S_ISSUE;
            timer_d = '0;
          end
        end else begin
          bo_d = bo_q + BW'(1);
        end
      end
      S_DRAIN: begin
        // One upstream pulse per slave assertion: wait for the release.
        if (!any_rsp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, counters, registered req_cyc_o and response pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retry_q   <= '0;
      bo_q      <= '0;
      req_cyc_q <= 1'b0;
      ack_q     <= 1'b0;
      rty_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retry_q   <= retry_d;
      bo_q      <= bo_d;
      req_cyc_q <= (state_d == S_ISSUE);
      ack_q     <= ack_d;
      rty_q     <= rty_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      tid_q     <= pop ? head.tid : '0;
    end
  end

  assign bus.req_cyc_o  = req_cyc_q;
  assign bus.req_we_o   = nonempty & head.we;
  assign bus.req_adr_o  = nonempty ? head.adr : '0;
  assign bus.req_dat_o  = nonempty ? head.dat : '0;
  assign bus.req_sel_o  = nonempty ? head.sel : '0;
  assign bus.req_tid_o  = nonempty ? head.tid : '0;
  assign bus.resp_ack_o = ack_q;
  assign bus.resp_rty_o = rty_q;
  assign bus.resp_err_o = err_q;
  assign bus.resp_dat_o = dat_q;
  assign bus.resp_tid_o = tid_q;
  assign bus.ovf_o      = ovf_q;
  assign bus.ovf_tid_o  = ovf_tid_q;
  assign bus.busy_o     = (state_q != S_IDLE) || nonempty;
  assign bus.count_o    = count_q;
  assign dbg_state_o    = state_q;
endmodule

// File: doc/fta_asynch2sync_q.md
Name: fta_asynch2sync_q

Overview:
- Parametrised, queued successor to the single-entry asynchronous-to-synchronous FTA bus bridge.
- Captures one-cycle request pulses from an asynchronous-style master into a FIFO of DEPTH entries.
- Presents each request to a synchronous slave as a level-held cycle, and converts the slave's level responses into single-cycle response pulses.
- Adds retry with backoff, a response timeout, overflow reporting and transaction-id tagging. It sits between CPU/DMA request ports and level-handshake peripherals.

Parameters:
DW, 128, data width in bits (multiple of 8)
AW, 32, address width
TW, 13, transaction-id width
DEPTH, 4, request FIFO entries (power of 2, >=2)
TIMEOUT, 1023, cycles in ISSUE without any response before an error is reported
MAX_RETRY, 3, number of slave retries absorbed before rty is forwarded upstream
BACKOFF, 4, idle cycles between a retry and the re-issue of the same request

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-low (asserted when 0)
req_cyc_i  input  1  request pulse (one cycle per request)
req_we_i  input  1  write enable
req_adr_i  input  AW  address
req_dat_i  input  DW  write data
req_sel_i  input  DW/8  byte selects
req_tid_i  input  TW  transaction id
ovf_o  output  1  pulse: request dropped because the FIFO was full
ovf_tid_o  output  TW  tid of the dropped request
resp_ack_o  output  1  ack pulse to master
resp_rty_o  output  1  retry-exhausted pulse
resp_err_o  output  1  error/timeout pulse
resp_dat_o  output  DW  read data, valid with resp_ack_o
resp_tid_o  output  TW  tid of the completed request
req_cyc_o  output  1  level cycle to slave
req_we_o, req_adr_o, req_dat_o, req_sel_o, req_tid_o  output  1/AW/DW/DW/8/TW  head-of-FIFO request fields
resp_ack_i  input  1  slave ack (level)
resp_rty_i  input  1  slave retry (level)
resp_err_i  input  1  slave error (level)
resp_dat_i  input  DW  slave read data
busy_o  output  1  state!=IDLE or FIFO non-empty
count_o  output  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (rst==0 at a clk edge):
  - All outputs 0, FIFO empty, pointers 0, state IDLE, retry/timer counters 0.
  - Queued and in-flight requests are discarded silently; no response is generated.
- Enqueue:
  - req_cyc_i==1 with count<DEPTH, or with count==DEPTH and a pop in the same cycle: the entry is written and the write pointer wraps modulo DEPTH.
  - Otherwise (full, no pop): the entry is not written; ovf_o=1 and ovf_tid_o=req_tid_i in the next cycle only.
  - Simultaneous push and pop leaves count unchanged.
- Latency: a pulse into an empty, idle bridge gives req_cyc_o=1 two cycles later.
- Output fields: req_*_o always show the FIFO head and are stable while req_cyc_o=1. req_cyc_o is registered.
- FSM:
  - IDLE: count>0 and ack/rty/err inputs all 0 -> ISSUE; req_cyc_o=1 next cycle; timer=0.
  - ISSUE: timer increments each cycle. Response priority is err > ack > rty.
    - err: resp_err_o pulse, pop, retry=0 -> DRAIN.
    - ack: resp_ack_o pulse with resp_dat_o=resp_dat_i, pop, retry=0 -> DRAIN.
    - rty with retry<MAX_RETRY: retry++, no upstream response -> BACKOFF.
    - rty with retry==MAX_RETRY: resp_rty_o pulse, pop, retry=0 -> DRAIN.
    - No response and timer==TIMEOUT: resp_err_o pulse, resp_dat_o=0, pop -> DRAIN.
    - req_cyc_o falls in the cycle after any of these transitions.
  - BACKOFF: counts BACKOFF cycles. When done and ack/rty/err inputs are all 0 -> ISSUE with the same head entry.
  - DRAIN: waits until ack/rty/err inputs are all 0 -> IDLE. This enforces edge semantics: one response pulse per slave assertion, however long the slave holds it.
- Response outputs are registered, one cycle wide, and resp_tid_o equals the tid of the popped head. All resp_*_o are 0 in any cycle without a response pulse.
- Ordering: strict FIFO; at most one request is outstanding on the slave side.

Test Plan:
- Single read: pulse tid=5 adr=0x1000 at cycle 0 -> req_cyc_o=1 at cycle 2; slave holds ack with dat=0xA5 for 4 cycles from cycle 5 -> exactly one resp_ack_o at cycle 6 with tid=5, dat=0xA5; req_cyc_o=0 at cycle 6; busy_o=0 once ack has dropped.
- Overflow: DEPTH=4, slave silent, 5 back-to-back pulses tid=1..5 -> count_o=4, ovf_o pulse with tid=5; acks then return resp tid=1,2,3,4 in order.
- Retry: slave answers rty, rty, ack -> two gaps of >=4 cycles with req_cyc_o=0, one resp_ack_o, no resp_rty_o. Slave answers rty 4 times -> a single resp_rty_o after the 4th, then the next entry issues.
- Timeout: TIMEOUT=15, slave never responds -> resp_err_o 15 cycles after req_cyc_o rises, resp_dat_o=0, entry popped.
- Priority: ack and err asserted together -> resp_err_o only. Push on a full FIFO in the same cycle as a pop -> accepted, no ovf_o.
- Reset mid-ISSUE with 3 entries queued -> the next cycle shows all outputs 0 and count_o=0, and no response pulse is produced.
